// File: rtl/mode_sel_multi.sv
// Single-button UI controller: synchronises and debounces a push-button, classifies
// short/long presses and steps the filter index or the video mode accordingly.
module mode_sel_multi #(
  parameter int C_DEB_CYC    = 1_000_000,
  parameter int C_TICK_CYC   = 1_000_000,
  parameter int C_LONG_TICKS = 100,
  parameter int C_REPEAT     = 0,
  parameter int C_NUM_MODES  = 4,
  parameter int C_NUM_FILT   = 8,
  localparam int MW = $clog2(C_NUM_MODES),
  localparam int FW = $clog2(C_NUM_FILT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sig_in,
  output logic          btn_level,
  output logic          short_press,
  output logic          long_press,
  output logic [MW-1:0] mode,
  output logic [FW-1:0] filt_idx,
  output logic          rgbmode,
  output logic          testmode,
  output logic [2:0]    rgbfilter
);

  localparam int DW = $clog2(C_DEB_CYC);
  localparam int TW = $clog2(C_TICK_CYC);
  localparam int HW = $clog2(C_LONG_TICKS + 1);

  localparam logic [DW-1:0] C_DEB_LAST  = DW'(C_DEB_CYC - 1);
  localparam logic [TW-1:0] C_TICK_LAST = TW'(C_TICK_CYC - 1);
  localparam logic [HW-1:0] C_HOLD_PRE  = HW'(C_LONG_TICKS - 1);
  localparam logic [HW-1:0] C_HOLD_MAX  = HW'(C_LONG_TICKS);
  localparam logic [MW-1:0] C_MODE_LAST = MW'(C_NUM_MODES - 1);
  localparam logic [FW-1:0] C_FILT_LAST = FW'(C_NUM_FILT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  logic          r_sync_p0;
  logic          r_sync_p1;
  logic [DW-1:0] r_deb_cnt;
  logic          r_btn_level;
  state_t        r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_short;
  logic          r_long;
  logic [MW-1:0] r_mode;
  logic [FW-1:0] r_filt;

  logic          w_tick_wrap;
  logic          w_thresh;
  logic [TW-1:0] w_tick_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [MW-1:0] w_mode_nxt;
  logic [FW-1:0] w_filt_nxt;
  logic [2:0]    w_filt3;
  logic          w_mode_b1;

  // Stage p0/p1: two-flop synchroniser, then the debounce counter on the synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0   <= 1'b0;
      r_sync_p1   <= 1'b0;
      r_deb_cnt   <= '0;
      r_btn_level <= 1'b0;
    end else begin
      r_sync_p0 <= sig_in;
      r_sync_p1 <= r_sync_p0;
      if (r_sync_p1 != r_btn_level) begin
        if (r_deb_cnt == C_DEB_LAST) begin
          r_btn_level <= r_sync_p1;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // The threshold fires on the tick that would take hold_cnt to C_LONG_TICKS
  assign w_tick_wrap = (r_tick_cnt == C_TICK_LAST);
  assign w_thresh    = w_tick_wrap && (r_hold_cnt == C_HOLD_PRE);
  assign w_tick_nxt  = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
  assign w_hold_nxt  = (r_hold_cnt == C_HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
  assign w_mode_nxt  = (r_mode == C_MODE_LAST) ? '0 : r_mode + 1'b1;
  assign w_filt_nxt  = (r_filt == C_FILT_LAST) ? '0 : r_filt + 1'b1;

  // Stage p2: press classifier, pulses and counters registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_hold_cnt <= '0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_mode     <= '0;
      r_filt     <= '0;
    end else begin
      r_short <= 1'b0;
      r_long  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_btn_level) begin
            r_state    <= S_HELD;
            r_tick_cnt <= '0;
            r_hold_cnt <= '0;
          end
        end
        S_HELD: begin
          if (w_thresh) begin
            r_long     <= 1'b1;
            r_mode     <= w_mode_nxt;
            r_tick_cnt <= '0;
            r_hold_cnt <= '0;
            r_state    <= S_LONG;
          end else if (!r_btn_level) begin
            r_short <= 1'b1;
            r_filt  <= w_filt_nxt;
            r_state <= S_IDLE;
          end else begin
            r_tick_cnt <= w_tick_nxt;
            if (w_tick_wrap) r_hold_cnt <= w_hold_nxt;
          end
        end
        S_LONG: begin
          if (!r_btn_level) begin
            r_state <= S_IDLE;
          end else if ((C_REPEAT != 0) && w_thresh) begin
            r_long     <= 1'b1;
            r_mode     <= w_mode_nxt;
            r_tick_cnt <= '0;
            r_hold_cnt <= '0;
          end else begin
            r_tick_cnt <= w_tick_nxt;
            if (w_tick_wrap) r_hold_cnt <= w_hold_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Narrow mode/filter widths read as zero in the missing decode bits
  if (MW >= 2) begin : g_mode_wide
    assign w_mode_b1 = r_mode[1];
  end else begin : g_mode_narrow
    assign w_mode_b1 = 1'b0;
  end

  if (FW >= 3) begin : g_filt_wide
    assign w_filt3 = r_filt[2:0];
  end else begin : g_filt_narrow
    assign w_filt3 = 3'(r_filt);
  end

  always_comb begin
    rgbfilter = 3'b000;
    case (w_filt3)
      3'd0: rgbfilter = 3'b000;
      3'd1: rgbfilter = 3'b100;
      3'd2: rgbfilter = 3'b010;
      3'd3: rgbfilter = 3'b001;
      3'd4: rgbfilter = 3'b110;
      3'd5: rgbfilter = 3'b101;
      3'd6: rgbfilter = 3'b011;
      3'd7: rgbfilter = 3'b111;
      default: rgbfilter = 3'b000;
    endcase
  end

  assign btn_level   = r_btn_level;
  assign short_press = r_short;
  assign long_press  = r_long;
  assign mode        = r_mode;
  assign filt_idx    = r_filt;
  assign rgbmode     = ~r_mode[0];
  assign testmode    = w_mode_b1;

endmodule

// File: tb/tb_mode_sel_multi.sv
// Bench for mode_sel_multi: one-shot and auto-repeat instances driven from the same button,
// checked each cycle against a press-age model plus directed literal expectations.
module tb_mode_sel_multi;

  localparam int DEB = 4;
  localparam int TCK = 10;
  localparam int LT  = 3;
  localparam int NM  = 3;
  localparam int NF  = 5;
  localparam int PER = TCK * LT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sig_in = 1'b0;

  logic       u0_btn, u0_sp, u0_lp, u0_rgbm, u0_tst;
  logic [1:0] u0_mode;
  logic [2:0] u0_filt, u0_rgbf;
  logic       u1_btn, u1_sp, u1_lp, u1_rgbm, u1_tst;
  logic [1:0] u1_mode;
  logic [2:0] u1_filt, u1_rgbf;

  mode_sel_multi #(.C_DEB_CYC(DEB), .C_TICK_CYC(TCK), .C_LONG_TICKS(LT), .C_REPEAT(0),
                   .C_NUM_MODES(NM), .C_NUM_FILT(NF)) u_rep0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .btn_level(u0_btn), .short_press(u0_sp),
    .long_press(u0_lp), .mode(u0_mode), .filt_idx(u0_filt), .rgbmode(u0_rgbm),
    .testmode(u0_tst), .rgbfilter(u0_rgbf));

  mode_sel_multi #(.C_DEB_CYC(DEB), .C_TICK_CYC(TCK), .C_LONG_TICKS(LT), .C_REPEAT(1),
                   .C_NUM_MODES(NM), .C_NUM_FILT(NF)) u_rep1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .btn_level(u1_btn), .short_press(u1_sp),
    .long_press(u1_lp), .mode(u1_mode), .filt_idx(u1_filt), .rgbmode(u1_rgbm),
    .testmode(u1_tst), .rgbfilter(u1_rgbf));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a press is "age" cycles old; long fires whenever age is a multiple of PER
  // (first time only unless repeating); a release before the first fire is a short press.
  logic [2:0] RGBF [8] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111};
  int m_s1, m_s2, m_lvl, m_run;
  int m_pr [2];
  int m_age [2];
  int m_fired [2];
  int m_mode [2];
  int m_filt [2];
  int m_sp [2];
  int m_lp [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      for (int k = 0; k < 2; k++) begin
        m_pr[k] = 0; m_age[k] = 0; m_fired[k] = 0;
        m_mode[k] = 0; m_filt[k] = 0; m_sp[k] = 0; m_lp[k] = 0;
      end
    end else begin
      int old_lvl;
      old_lvl = m_lvl;
      if (m_s2 != m_lvl) begin
        if (m_run + 1 == DEB) begin m_lvl = m_s2; m_run = 0; end
        else m_run = m_run + 1;
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = int'(sig_in);
      for (int k = 0; k < 2; k++) begin
        m_sp[k] = 0; m_lp[k] = 0;
        if (m_pr[k] == 0) begin
          if (old_lvl != 0) begin m_pr[k] = 1; m_age[k] = 0; m_fired[k] = 0; end
        end else begin
          m_age[k] = m_age[k] + 1;
          if (m_fired[k] == 0) begin
            if (m_age[k] % PER == 0) begin m_lp[k] = 1; m_fired[k] = 1; end
            else if (old_lvl == 0) begin m_sp[k] = 1; m_pr[k] = 0; end
          end else begin
            if (old_lvl == 0) m_pr[k] = 0;
            else if (k == 1 && m_age[k] % PER == 0) begin m_lp[k] = 1; m_fired[k]++; end
          end
        end
        if (m_lp[k] != 0) m_mode[k] = (m_mode[k] + 1) % NM;
        if (m_sp[k] != 0) m_filt[k] = (m_filt[k] + 1) % NF;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("btn0", int'(u0_btn), m_lvl);
      chk("sp0", int'(u0_sp), m_sp[0]);
      chk("lp0", int'(u0_lp), m_lp[0]);
      chk("mode0", int'(u0_mode), m_mode[0]);
      chk("filt0", int'(u0_filt), m_filt[0]);
      chk("rgbm0", int'(u0_rgbm), (m_mode[0] % 2 == 0) ? 1 : 0);
      chk("tst0", int'(u0_tst), (m_mode[0] / 2) % 2);
      chk("rgbf0", int'(u0_rgbf), int'(RGBF[m_filt[0]]));
      chk("btn1", int'(u1_btn), m_lvl);
      chk("sp1", int'(u1_sp), m_sp[1]);
      chk("lp1", int'(u1_lp), m_lp[1]);
      chk("mode1", int'(u1_mode), m_mode[1]);
      chk("filt1", int'(u1_filt), m_filt[1]);
      chk("rgbm1", int'(u1_rgbm), (m_mode[1] % 2 == 0) ? 1 : 0);
      chk("tst1", int'(u1_tst), (m_mode[1] / 2) % 2);
      chk("rgbf1", int'(u1_rgbf), int'(RGBF[m_filt[1]]));
    end
  end

  int gcyc = 0;
  int t_rise = -1;
  int t_long = -1;
  int prev_btn = 0;
  int n_btn_hi = 0;
  int c_sp0 = 0;
  int c_lp0 = 0;
  int c_lp1 = 0;
  int q1 [$];

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      gcyc++;
      if (u0_btn && prev_btn == 0) t_rise = gcyc;
      prev_btn = int'(u0_btn);
      if (u0_btn) n_btn_hi++;
      if (u0_sp) c_sp0++;
      if (u0_lp) begin
        c_lp0++;
        if (t_long < 0) t_long = gcyc;
      end
      if (u1_lp) begin
        c_lp1++;
        q1.push_back(int'(u1_mode));
      end
    end
  endtask

  task automatic press(input int hold, input int after);
    sig_in = 1'b1;
    run(hold);
    sig_in = 1'b0;
    run(after);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2);
  endtask

  initial begin
    int t0, sp_base, lp_base;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;

    // Reset with the button toggling
    for (int i = 0; i < 6; i++) begin
      sig_in = ~sig_in;
      run(1);
    end
    chk("rst_mode", int'(u0_mode), 0);
    chk("rst_filt", int'(u0_filt), 0);
    chk("rst_rgbmode", int'(u0_rgbm), 1);
    chk("rst_testmode", int'(u0_tst), 0);
    chk("rst_rgbfilter", int'(u0_rgbf), 0);
    chk("rst_pulses", c_sp0 + c_lp0 + c_lp1, 0);
    chk("rst_btn", n_btn_hi, 0);
    sig_in = 1'b0;
    rst_n = 1'b1;
    run(5);

    // Glitch rejection, then a real press
    press(3, 10);
    chk("glitch_btn", n_btn_hi, 0);
    chk("glitch_pulses", c_sp0 + c_lp0 + c_lp1, 0);
    t0 = gcyc;
    t_rise = -1;
    press(20, 15);
    chk("deb_rise_lat", t_rise - t0, 6);

    // Short presses and filter wrap
    do_reset();
    sp_base = c_sp0;
    press(15, 15);
    chk("sp_count1", c_sp0 - sp_base, 1);
    chk("sp_filt1", int'(u0_filt), 1);
    chk("sp_rgbf1", int'(u0_rgbf), 3'b100);
    chk("sp_mode", int'(u0_mode), 0);
    for (int i = 0; i < 3; i++) press(15, 15);
    chk("sp_filt4", int'(u0_filt), 4);
    chk("sp_rgbf4", int'(u0_rgbf), 3'b110);
    press(15, 15);
    chk("sp_filt_wrap", int'(u0_filt), 0);
    chk("sp_count5", c_sp0 - sp_base, 5);

    // Long presses, one-shot and auto-repeat
    do_reset();
    sp_base = c_sp0;
    lp_base = c_lp0;
    c_lp1 = 0;
    q1.delete();
    t_rise = -1;
    t_long = -1;
    press(100, 15);
    chk("lp_count", c_lp0 - lp_base, 1);
    chk("lp_no_short", c_sp0 - sp_base, 0);
    chk("lp_mode1", int'(u0_mode), 1);
    chk("lp_rgbmode", int'(u0_rgbm), 0);
    chk("lp_latency", t_long - t_rise, 31);
    chk("rep_count", c_lp1, 3);
    chk("rep_seq_len", q1.size(), 3);
    if (q1.size() == 3) begin
      chk("rep_seq0", q1[0], 1);
      chk("rep_seq1", q1[1], 2);
      chk("rep_seq2", q1[2], 0);
    end
    press(100, 15);
    chk("lp_mode2", int'(u0_mode), 2);
    chk("lp_testmode2", int'(u0_tst), 1);
    press(100, 15);
    chk("lp_mode_wrap", int'(u0_mode), 0);
    chk("lp_testmode0", int'(u0_tst), 0);

    // Release coinciding with the threshold, and one cycle earlier
    lp_base = c_lp0;
    sp_base = c_sp0;
    press(30, 15);
    chk("tie_long", c_lp0 - lp_base, 1);
    chk("tie_no_short", c_sp0 - sp_base, 0);
    chk("tie_mode", int'(u0_mode), 1);
    press(29, 15);
    chk("pre_tie_short", c_sp0 - sp_base, 1);
    chk("pre_tie_lp", c_lp0 - lp_base, 1);
    chk("pre_tie_filt", int'(u0_filt), 1);

    // Reset in the middle of a held press, button still down afterwards
    sig_in = 1'b1;
    run(26);
    rst_n = 1'b0;
    run(2);
    chk("midrst_mode0", int'(u0_mode), 0);
    chk("midrst_mode1", int'(u1_mode), 0);
    chk("midrst_btn", int'(u0_btn), 0);
    t_rise = -1;
    t_long = -1;
    rst_n = 1'b1;
    run(50);
    chk("midrst_latency", t_long - t_rise, 31);
    chk("midrst_newmode", int'(u0_mode), 1);
    sig_in = 1'b0;
    run(20);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
